ysyx_25040129_axi_xbar_n: RTL
=============================

Name: ysyx_25040129_axi_xbar_n

Overview:
- Parametrised 1-master / NS-slave AXI4-style crossbar between the core LSU/IFU arbiter and all memory-mapped targets: SoC, RTC, SRAM and future devices.
- Routes both read and write channels by base/mask address decode.
- Read and write paths are independent; a read and a write may be in flight at the same time.
- An access that matches no slave is answered locally with DECERR. A matching slave that sends a non-OKAY response is passed through unchanged.

Parameters:
- NS, 3: number of slave ports (1..8).
- SLV_BASE, {32'h8000_0000, 32'h0f00_0000, 32'h0200_0048}: packed NS*32 base addresses; slave i occupies bits [32*i+:32].
- SLV_MASK, {32'h8000_0000, 32'hff00_0000, 32'hffff_fff8}: packed NS*32 compare masks. Slave i hits when (addr & mask_i) == (base_i & mask_i).
- TIMEOUT, 1024: watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- araddr/arsize/arlen/arburst/arsatp/arvalid  input  32/3/8/2/32/1  master read address.
- arready  output  1  master read address ready.
- rdata/rresp/rlast/rvalid  output  32/2/1/1  master read data.
- rready  input  1  master read data ready.
- awaddr/awsatp/awvalid  input  32/32/1  master write address.
- awready  output  1  master write address ready.
- wdata/wstrb/wvalid  input  32/4/1  master write data (single beat).
- wready  output  1  master write data ready.
- bresp/bvalid  output  2/1  master write response.
- bready  input  1  master write response ready.
- s_araddr/s_arsize/s_arlen/s_arburst/s_arsatp  output  NS*32/NS*3/NS*8/NS*2/NS*32  per-slave read address.
- s_arvalid  output  NS  per-slave read address valid.
- s_arready  input  NS  per-slave read address ready.
- s_rdata/s_rresp/s_rlast/s_rvalid  input  NS*32/NS*2/NS/NS  per-slave read data.
- s_rready  output  NS  per-slave read data ready.
- s_awaddr/s_awsatp/s_wdata/s_wstrb  output  NS*32/NS*32/NS*32/NS*4  per-slave write address/data.
- s_awvalid/s_wvalid/s_bready  output  NS each  per-slave write handshakes.
- s_awready/s_wready/s_bvalid  input  NS each  per-slave write handshakes.
- s_bresp  input  NS*2  per-slave write response.

Behaviour:
- Reset (rst=0): both FSMs go to IDLE; all valid/ready outputs are 0; rdata, rresp and bresp are 0; beat counter is 0.
- Decode: the lowest-index matching slave wins. No match selects the internal error target.
- Read FSM states: R_IDLE, R_FWD, R_ERR.
  - R_IDLE: arready=0. On arvalid, register the slave index, go to R_FWD, or go to R_ERR on no match.
  - Latency: 1 cycle from arvalid to s_arvalid.
  - The master holds AR stable until accepted.
- R_FWD: AR, R and ready signals are wired combinationally to the selected slave only. Unselected slaves see valid/ready = 0.
  - Return to R_IDLE on rvalid & rready & rlast.
- R_ERR:
  - Assert arready for 1 cycle and latch arlen into the beat counter.
  - Then drive rvalid=1, rresp=2'b11, rdata=0 for arlen+1 beats; rlast on the final beat.
  - Decrement on each rready; return to R_IDLE after the last handshake.
- Write FSM states: W_IDLE, W_FWD, W_ERR. Single-beat writes only.
  - W_IDLE: on awvalid, decode and register the index (1-cycle latency).
  - W_FWD: forward AW, W and B to the selected slave. AW and W may complete in either order or together. Return to W_IDLE on bvalid & bready.
  - W_ERR: accept AW and W (awready and wready each pulse once, when the corresponding valid is high). After both are accepted, bvalid=1, bresp=2'b11 until bready, then W_IDLE.
- A read and a write to the same slave concurrently are legal; the slave arbitrates.
- Reset mid-transaction aborts without completing the handshake. Slaves share the same reset.
- Stray slave valids (s_rvalid or s_bvalid on an unselected index) are ignored and never forwarded.

Optional Feature:
- Macro YSYX_25040129_XBAR_TIMEOUT_EN.
- When defined:
  - Each FSM has a counter that clears on every forwarded handshake and increments while in *_FWD.
  - When the counter reaches TIMEOUT, the read FSM returns SLVERR (2'b10) for the remaining beats; the write FSM returns bresp=2'b10.
  - Both then drop the slave: its s_rready/s_bready are held 0 and late responses are ignored until the FSM is back in IDLE.
  - A sticky timeout status bit is also set for debug.
- When undefined: no counter exists, and the FSM waits indefinitely.

Test Plan:
- Read 0x0200_0048, arlen=0, slave0 returns 0x1234_5678 → s_arvalid[0] asserted 1 cycle after arvalid; rdata=0x1234_5678, rresp=00, rlast=1; FSM back in R_IDLE the next cycle.
- Burst read 0x8000_0000, arlen=3 with rready toggling → 4 beats from slave2 in order, rlast only on beat 4, and s_rready[0]/[1] stay 0 throughout.
- Read 0x4000_0000, arlen=1 (no match) → 2 beats of rresp=11, rdata=0, rlast on beat 2. Write to 0x4000_0000 → bresp=11 after both AW and W are accepted, with W presented 3 cycles before AW.
- Concurrent write 0x0f00_0010 (wstrb=4'b0011) and read 0x8000_0004 → both complete independently; slave1 sees wstrb=0011; no cross-talk between the channels.
- rst=0 asserted mid-burst at beat 2 of 4 → next cycle all valid outputs are 0 and both FSMs are IDLE; a fresh read after rst=1 succeeds.
- With YSYX_25040129_XBAR_TIMEOUT_EN and TIMEOUT=16, slave2 never raises s_rvalid → rresp=10 with rlast on cycle 17 after the AR handshake; a late s_rvalid[2] is ignored.

Source files
------------

// File: rtl/ysyx_25040129_axi_xbar_n.sv
// 1-master / NS-slave AXI4-style crossbar with base/mask decode and a local DECERR target.
// Define YSYX_25040129_XBAR_TIMEOUT_EN to add a per-channel watchdog that answers SLVERR.
module ysyx_25040129_axi_xbar_n #(
  parameter int               NS       = 3,
  parameter logic [NS*32-1:0] SLV_BASE = {32'h8000_0000, 32'h0f00_0000, 32'h0200_0048},
  parameter logic [NS*32-1:0] SLV_MASK = {32'h8000_0000, 32'hff00_0000, 32'hffff_fff8}
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
  , parameter int             TIMEOUT  = 1024
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    araddr,
  input  logic [2:0]     arsize,
  input  logic [7:0]     arlen,
  input  logic [1:0]     arburst,
  input  logic [31:0]    arsatp,
  input  logic           arvalid,
  output logic           arready,
  output logic [31:0]    rdata,
  output logic [1:0]     rresp,
  output logic           rlast,
  output logic           rvalid,
  input  logic           rready,
  input  logic [31:0]    awaddr,
  input  logic [31:0]    awsatp,
  input  logic           awvalid,
  output logic           awready,
  input  logic [31:0]    wdata,
  input  logic [3:0]     wstrb,
  input  logic           wvalid,
  output logic           wready,
  output logic [1:0]     bresp,
  output logic           bvalid,
  input  logic           bready,
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
  output logic [1:0]     to_status,
`endif
  output logic [NS*32-1:0] s_araddr,
  output logic [NS*3-1:0]  s_arsize,
  output logic [NS*8-1:0]  s_arlen,
  output logic [NS*2-1:0]  s_arburst,
  output logic [NS*32-1:0] s_arsatp,
  output logic [NS-1:0]    s_arvalid,
  input  logic [NS-1:0]    s_arready,
  input  logic [NS*32-1:0] s_rdata,
  input  logic [NS*2-1:0]  s_rresp,
  input  logic [NS-1:0]    s_rlast,
  input  logic [NS-1:0]    s_rvalid,
  output logic [NS-1:0]    s_rready,
  output logic [NS*32-1:0] s_awaddr,
  output logic [NS*32-1:0] s_awsatp,
  output logic [NS*32-1:0] s_wdata,
  output logic [NS*4-1:0]  s_wstrb,
  output logic [NS-1:0]    s_awvalid,
  output logic [NS-1:0]    s_wvalid,
  output logic [NS-1:0]    s_bready,
  input  logic [NS-1:0]    s_awready,
  input  logic [NS-1:0]    s_wready,
  input  logic [NS-1:0]    s_bvalid,
  input  logic [NS*2-1:0]  s_bresp
);

  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {R_IDLE, R_FWD, R_ERR} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_ERR} w_state_e;

  // Returns {miss, index}; scanning downwards lets the lowest matching index win.
  function automatic logic [IW:0] decode(input logic [31:0] addr);
    logic [IW:0] res;
    res = {1'b1, {IW{1'b0}}};
    for (int i = NS - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]))
        res = {1'b0, IW'(i)};
    end
    return res;
  endfunction

  r_state_e      r_state_q;
  logic [IW-1:0] r_sel_q;
  logic          r_ar_done_q, r_err_ardy_q, r_err_rvalid_q, r_err_rlast_q;
  logic [1:0]    r_err_resp_q;
  logic [7:0]    r_cnt_q;
  w_state_e      w_state_q;
  logic [IW-1:0] w_sel_q;
  logic          w_aw_done_q, w_w_done_q, w_err_awrdy_q, w_err_wrdy_q, w_err_bvalid_q;
  logic [1:0]    w_err_resp_q;

  logic [IW:0]   ar_dec, aw_dec;
  logic          r_fwd, w_fwd, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic          sel_arready, sel_rvalid, sel_rlast, sel_awready, sel_wready, sel_bvalid;
  logic [31:0]   sel_rdata;
  logic [1:0]    sel_rresp, sel_bresp;

  assign ar_dec = decode(araddr);
  assign aw_dec = decode(awaddr);
  assign r_fwd  = (r_state_q == R_FWD);
  assign w_fwd  = (w_state_q == W_FWD);

  always_comb begin
    sel_arready = 1'b0;
    sel_rvalid  = 1'b0;
    sel_rlast   = 1'b0;
    sel_rresp   = 2'b00;
    sel_rdata   = 32'd0;
    sel_awready = 1'b0;
    sel_wready  = 1'b0;
    sel_bvalid  = 1'b0;
    sel_bresp   = 2'b00;
    for (int i = 0; i < NS; i++) begin
      if (r_sel_q == IW'(i)) begin
        sel_arready = s_arready[i];
        sel_rvalid  = s_rvalid[i];
        sel_rlast   = s_rlast[i];
        sel_rresp   = s_rresp[2*i +: 2];
        sel_rdata   = s_rdata[32*i +: 32];
      end
      if (w_sel_q == IW'(i)) begin
        sel_awready = s_awready[i];
        sel_wready  = s_wready[i];
        sel_bvalid  = s_bvalid[i];
        sel_bresp   = s_bresp[2*i +: 2];
      end
    end
  end

  // Payloads are broadcast; only the handshakes are steered to the selected slave.
  for (genvar gi = 0; gi < NS; gi++) begin : g_slv
    assign s_araddr[32*gi +: 32]  = araddr;
    assign s_arsize[3*gi +: 3]    = arsize;
    assign s_arlen[8*gi +: 8]     = arlen;
    assign s_arburst[2*gi +: 2]   = arburst;
    assign s_arsatp[32*gi +: 32]  = arsatp;
    assign s_awaddr[32*gi +: 32]  = awaddr;
    assign s_awsatp[32*gi +: 32]  = awsatp;
    assign s_wdata[32*gi +: 32]   = wdata;
    assign s_wstrb[4*gi +: 4]     = wstrb;
    assign s_arvalid[gi] = r_fwd && (r_sel_q == IW'(gi)) && arvalid && !r_ar_done_q;
    assign s_rready[gi]  = r_fwd && (r_sel_q == IW'(gi)) && rready;
    assign s_awvalid[gi] = w_fwd && (w_sel_q == IW'(gi)) && awvalid && !w_aw_done_q;
    assign s_wvalid[gi]  = w_fwd && (w_sel_q == IW'(gi)) && wvalid && !w_w_done_q;
    assign s_bready[gi]  = w_fwd && (w_sel_q == IW'(gi)) && bready;
  end

  assign arready = r_fwd ? (sel_arready && !r_ar_done_q) : r_err_ardy_q;
  assign rvalid  = r_fwd ? sel_rvalid : r_err_rvalid_q;
  assign rlast   = r_fwd ? sel_rlast  : r_err_rlast_q;
  assign rdata   = r_fwd ? sel_rdata  : 32'd0;
  assign rresp   = r_fwd ? sel_rresp  : (r_err_rvalid_q ? r_err_resp_q : 2'b00);
  assign awready = w_fwd ? (sel_awready && !w_aw_done_q) : w_err_awrdy_q;
  assign wready  = w_fwd ? (sel_wready && !w_w_done_q) : w_err_wrdy_q;
  assign bvalid  = w_fwd ? sel_bvalid : w_err_bvalid_q;
  assign bresp   = w_fwd ? sel_bresp  : (w_err_bvalid_q ? w_err_resp_q : 2'b00);

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;

`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_q, w_to_q;
  logic          r_to_flag_q, w_to_flag_q;
  assign to_status = {w_to_flag_q, r_to_flag_q};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_q      <= R_IDLE;
      r_sel_q        <= '0;
      r_ar_done_q    <= 1'b0;
      r_err_ardy_q   <= 1'b0;
      r_err_rvalid_q <= 1'b0;
      r_err_rlast_q  <= 1'b0;
      r_err_resp_q   <= 2'b00;
      r_cnt_q        <= 8'd0;
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
      r_to_q         <= '0;
      r_to_flag_q    <= 1'b0;
`endif
    end else begin
      case (r_state_q)
        R_IDLE: begin
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
          r_to_q <= '0;
`endif
          if (arvalid) begin
            r_ar_done_q <= 1'b0;
            if (ar_dec[IW]) begin
              r_state_q    <= R_ERR;
              r_err_ardy_q <= 1'b1;
              r_err_resp_q <= 2'b11;
            end else begin
              r_state_q <= R_FWD;
              r_sel_q   <= ar_dec[IW-1:0];
            end
          end
        end
        R_FWD: begin
          // r_cnt_q tracks remaining beats so a watchdog abort knows where to resume.
          if (ar_hs) begin
            r_ar_done_q <= 1'b1;
            r_cnt_q     <= arlen;
          end
          if (r_hs) begin
            r_cnt_q <= r_cnt_q - 8'd1;
            if (rlast) begin
              r_state_q   <= R_IDLE;
              r_ar_done_q <= 1'b0;
              r_cnt_q     <= 8'd0;
            end
          end
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
          if (ar_hs || r_hs) begin
            r_to_q <= '0;
          end else if (r_to_q == TW'(TIMEOUT - 1)) begin
            r_state_q    <= R_ERR;
            r_err_resp_q <= 2'b10;
            r_to_flag_q  <= 1'b1;
            if (r_ar_done_q) begin
              r_err_rvalid_q <= 1'b1;
              r_err_rlast_q  <= (r_cnt_q == 8'd0);
            end else begin
              r_err_ardy_q <= 1'b1;
            end
          end else begin
            r_to_q <= r_to_q + TW'(1);
          end
`endif
        end
        R_ERR: begin
          if (!r_ar_done_q) begin
            if (r_err_ardy_q && arvalid) begin
              r_err_ardy_q   <= 1'b0;
              r_ar_done_q    <= 1'b1;
              r_cnt_q        <= arlen;
              r_err_rvalid_q <= 1'b1;
              r_err_rlast_q  <= (arlen == 8'd0);
            end else if (arvalid) begin
              r_err_ardy_q <= 1'b1;
            end
          end else if (r_err_rvalid_q && rready) begin
            if (r_err_rlast_q) begin
              r_state_q      <= R_IDLE;
              r_err_rvalid_q <= 1'b0;
              r_err_rlast_q  <= 1'b0;
              r_ar_done_q    <= 1'b0;
              r_cnt_q        <= 8'd0;
            end else begin
              r_cnt_q       <= r_cnt_q - 8'd1;
              r_err_rlast_q <= (r_cnt_q == 8'd1);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_q      <= W_IDLE;
      w_sel_q        <= '0;
      w_aw_done_q    <= 1'b0;
      w_w_done_q     <= 1'b0;
      w_err_awrdy_q  <= 1'b0;
      w_err_wrdy_q   <= 1'b0;
      w_err_bvalid_q <= 1'b0;
      w_err_resp_q   <= 2'b00;
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
      w_to_q         <= '0;
      w_to_flag_q    <= 1'b0;
`endif
    end else begin
      case (w_state_q)
        W_IDLE: begin
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
          w_to_q <= '0;
`endif
          if (awvalid) begin
            w_aw_done_q <= 1'b0;
            w_w_done_q  <= 1'b0;
            if (aw_dec[IW]) begin
              w_state_q     <= W_ERR;
              w_err_awrdy_q <= 1'b1;
              w_err_resp_q  <= 2'b11;
            end else begin
              w_state_q <= W_FWD;
              w_sel_q   <= aw_dec[IW-1:0];
            end
          end
        end
        W_FWD: begin
          if (aw_hs) w_aw_done_q <= 1'b1;
          if (w_hs)  w_w_done_q  <= 1'b1;
          if (b_hs) begin
            w_state_q   <= W_IDLE;
            w_aw_done_q <= 1'b0;
            w_w_done_q  <= 1'b0;
          end
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
          if (aw_hs || w_hs || b_hs) begin
            w_to_q <= '0;
          end else if (w_to_q == TW'(TIMEOUT - 1)) begin
            w_state_q    <= W_ERR;
            w_err_resp_q <= 2'b10;
            w_to_flag_q  <= 1'b1;
          end else begin
            w_to_q <= w_to_q + TW'(1);
          end
`endif
        end
        W_ERR: begin
          // AW and W are each acknowledged once, in whatever order the master offers them.
          if (w_err_awrdy_q) begin
            if (awvalid) begin
              w_err_awrdy_q <= 1'b0;
              w_aw_done_q   <= 1'b1;
            end
          end else if (!w_aw_done_q && awvalid) begin
            w_err_awrdy_q <= 1'b1;
          end
          if (w_err_wrdy_q) begin
            if (wvalid) begin
              w_err_wrdy_q <= 1'b0;
              w_w_done_q   <= 1'b1;
            end
          end else if (!w_w_done_q && wvalid) begin
            w_err_wrdy_q <= 1'b1;
          end
          if (w_err_bvalid_q) begin
            if (bready) begin
              w_state_q      <= W_IDLE;
              w_err_bvalid_q <= 1'b0;
              w_aw_done_q    <= 1'b0;
              w_w_done_q     <= 1'b0;
            end
          end else if (w_aw_done_q && w_w_done_q) begin
            w_err_bvalid_q <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

endmodule
